fp32_add_arbiter: RTL and testbench
===================================

Name: fp32_add_arbiter

Overview:
- Shares one pipelined fp32 adder (registered output, ADD_LAT cycles) between N_REQ requesters.
- Each requester has a valid/ready operand channel and a valid/ready result channel with a one-entry result slot.
- Grants are round-robin. Each result is routed back to its owner using a tag pipeline that matches the adder latency.
- Sits between the FPADD datapath instance and the SMC lanes that issue additions.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADD_LAT, 1, adder latency in clock edges from operand sample to sum valid
CNT_W, 32, width of issued-operation counter

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
req_valid  in  N_REQ  requester i has an operand pair
req_a  in  32*N_REQ  operand A, requester i at [32i+31:32i]
req_b  in  32*N_REQ  operand B, same packing
req_ready  out  N_REQ  one-hot grant; accept = req_valid[i] & req_ready[i]
rsp_valid  out  N_REQ  slot i holds a result
rsp_data  out  32*N_REQ  result for requester i, same packing
rsp_ready  in  N_REQ  requester i consumes its result
add_a  out  32  registered operand A to adder
add_b  out  32  registered operand B to adder
add_sum  in  32  adder output, valid ADD_LAT edges after add_a/add_b change
busy  out  1  any slot occupied (in flight or holding a result)
issue_cnt  out  CNT_W  accepted operations since reset, wraps

Behaviour:
- Reset (async, rst=1): occ, rsp_valid, rsp_data, add_a, add_b, tag pipe, issue_cnt and busy all go to 0. The round-robin pointer goes to 0. In-flight operations are dropped, and any late add_sum is ignored.
- Occupancy: occ[i] is set at the accept edge. It clears at the edge where rsp_valid[i] & rsp_ready[i].
- Eligibility: elig[i] = req_valid[i] & ~occ[i], using registered occ. A requester is never re-granted at the same edge its response is consumed. The earliest re-accept is one cycle later.
- Arbitration (combinational from registered state):
  - Scan from ptr upward, modulo N_REQ. The first eligible index g is granted, and req_ready is one-hot at g.
  - If no index is eligible, req_ready = 0.
  - req_ready never depends on req_a/req_b.
  - req_ready[i] may be 1 only if req_valid[i] = 1.
- On an accept edge:
  - add_a <= req_a[g] and add_b <= req_b[g].
  - Tag stage 0 <= {1, g}.
  - ptr <= (g+1) mod N_REQ.
  - issue_cnt <= issue_cnt+1, wrapping modulo 2^CNT_W.
- With no accept: add_a/add_b hold their values, tag stage 0 <= {0, x}, and ptr holds.
- Tag pipe: depth ADD_LAT+1 stages, shifting every cycle. The last stage is aligned with add_sum.
- Capture: when the last tag stage is valid with id k, rsp_data[k] <= add_sum and rsp_valid[k] <= 1 at that edge.
- Latency: rsp_valid[k] rises exactly ADD_LAT+1 edges after the accept edge. For ADD_LAT=1, accept at E0 gives rsp_valid after E2.
- Throughput:
  - One accept per cycle across all requesters.
  - Per requester: at most one operation outstanding. The slot stays occupied from accept through result consumption.
- A capture into slot k while rsp_valid[k]=1 cannot occur, because occ blocks re-grant. The bench asserts this never happens.
- Simultaneous capture for k and response handshake for j≠k are independent.
- The adder's numerical behaviour (NaN, Inf, denormals, rounding) passes through unchanged; the arbiter never inspects data.
- busy = |occ.

Test Plan:
- Single requester: rst, then N_REQ=4, ADD_LAT=1, req 0 sends a=0x3F800000, b=0x40000000 with rsp_ready=1 -> accept at E0; add_a=0x3F800000 after E0; rsp_valid[0] after E2 with rsp_data[0]=0x40400000; rsp_valid[0] clears at E3; issue_cnt=1.
- All four requesters valid continuously, each with a distinct operand pair -> grants at consecutive edges in order 0,1,2,3. Each result returns to its own index with the correct sum. ptr then wraps so the next grant goes to 0.
- Backpressure: req 2 with rsp_ready[2]=0 for 10 cycles while req_valid[2] stays 1 -> req_ready[2]=0 throughout and rsp_data[2] holds. The other requesters are still served round-robin. The first re-accept of req 2 occurs one cycle after the rsp handshake.
- Special values via the adder: req 1 sends a=0x7F800000, b=0xFF800000 -> rsp_data[1]=0x7FC00000 routed to index 1 only.
- Reset mid-operation: assert rst one cycle after accepting req 3 -> all outputs 0 immediately. No rsp_valid appears afterwards, and busy=0.
- ADD_LAT=3 build: accept at E0 -> rsp_valid after E4. Back-to-back accepts from 0 and 1 return in issue order with correct tags.

Source files
------------

// File: rtl/fp32_add_arbiter.sv
// Round-robin arbiter sharing one pipelined fp32 adder between N_REQ requesters.
// A tag pipe matched to the adder latency steers each sum back to its owner's result slot.
module fp32_add_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADD_LAT = 1,
    parameter int CNT_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [32*N_REQ-1:0]  req_a,
    input  logic [32*N_REQ-1:0]  req_b,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [32*N_REQ-1:0]  rsp_data,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic [31:0]          add_a,
    output logic [31:0]          add_b,
    input  logic [31:0]          add_sum,
    output logic                 busy,
    output logic [CNT_W-1:0]     issue_cnt
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int DEPTH = ADD_LAT + 1;

    logic [N_REQ-1:0]            occ_r;
    logic [N_REQ-1:0]            occ_next_s;
    logic [N_REQ-1:0]            elig_s;
    logic [N_REQ-1:0]            consume_s;
    logic [N_REQ-1:0]            cap_oh_s;
    logic [N_REQ-1:0]            rsp_valid_r;
    logic [N_REQ-1:0]            rsp_valid_next_s;
    logic [32*N_REQ-1:0]         rsp_data_r;
    logic [ID_W-1:0]             ptr_r;
    logic [ID_W-1:0]             ptr_next_s;
    logic [ID_W:0]               pick_s;
    logic                        grant_vld_s;
    logic [ID_W-1:0]             grant_idx_s;
    logic [31:0]                 add_a_r;
    logic [31:0]                 add_b_r;
    logic [CNT_W-1:0]            issue_cnt_r;
    logic                        busy_r;
    logic [DEPTH-1:0]            tag_vld_r;
    logic [DEPTH-1:0][ID_W-1:0]  tag_id_r;

    // Returns {found, index} of the first eligible requester at or above ptr, wrapping.
    function automatic logic [ID_W:0] pick_grant(input logic [N_REQ-1:0] elig,
                                                  input logic [ID_W-1:0]  ptr);
        logic [ID_W:0] res;
        int            cand;
        res = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end else begin
                cand = cand;
            end
            if (!res[ID_W] && elig[ID_W'(cand)]) begin
                res = {1'b1, ID_W'(cand)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Grant selection: eligibility uses registered occupancy, never operand data.
    always_comb begin
        elig_s      = req_valid & ~occ_r;
        pick_s      = pick_grant(elig_s, ptr_r);
        grant_vld_s = pick_s[ID_W];
        grant_idx_s = pick_s[ID_W-1:0];
        req_ready   = '0;
        if (grant_vld_s) begin
            req_ready[grant_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state for pointer, occupancy and result-slot valid bits.
    always_comb begin
        consume_s  = rsp_valid_r & rsp_ready;
        occ_next_s = (occ_r & ~consume_s) | req_ready;
        cap_oh_s   = '0;
        if (tag_vld_r[DEPTH-1]) begin
            cap_oh_s[tag_id_r[DEPTH-1]] = 1'b1;
        end else begin
            cap_oh_s = '0;
        end
        rsp_valid_next_s = (rsp_valid_r & ~consume_s) | cap_oh_s;
        ptr_next_s       = ptr_r;
        if (grant_vld_s) begin
            if (grant_idx_s == ID_W'(N_REQ - 1)) begin
                ptr_next_s = '0;
            end else begin
                ptr_next_s = grant_idx_s + ID_W'(1);
            end
        end else begin
            ptr_next_s = ptr_r;
        end
    end

    // Arbitration state, operand registers and issue counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_r       <= '0;
            busy_r      <= 1'b0;
            ptr_r       <= '0;
            add_a_r     <= 32'h0000_0000;
            add_b_r     <= 32'h0000_0000;
            issue_cnt_r <= '0;
        end else begin
            occ_r  <= occ_next_s;
            busy_r <= |occ_next_s;
            ptr_r  <= ptr_next_s;
            if (grant_vld_s) begin
                add_a_r     <= req_a[32*grant_idx_s +: 32];
                add_b_r     <= req_b[32*grant_idx_s +: 32];
                issue_cnt_r <= issue_cnt_r + CNT_W'(1);
            end
        end
    end

    // Tag pipe: stage DEPTH-1 lines up with add_sum for the op issued DEPTH-1 edges earlier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld_r <= '0;
            tag_id_r  <= '0;
        end else begin
            tag_vld_r <= {tag_vld_r[DEPTH-2:0], grant_vld_s};
            tag_id_r  <= {tag_id_r[DEPTH-2:0], (grant_vld_s ? grant_idx_s : ID_W'(0))};
        end
    end

    // Result slots: capture the adder output into the tagged owner's slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_r <= '0;
            rsp_data_r  <= '0;
        end else begin
            rsp_valid_r <= rsp_valid_next_s;
            for (int i = 0; i < N_REQ; i++) begin
                if (cap_oh_s[i]) begin
                    rsp_data_r[32*i +: 32] <= add_sum;
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign add_a     = add_a_r;
    assign add_b     = add_b_r;
    assign busy      = busy_r;
    assign issue_cnt = issue_cnt_r;

endmodule

// File: tb/tb_fp32_add_arbiter.sv
// Directed bench for fp32_add_arbiter: two builds (ADD_LAT=1 and ADD_LAT=3) share the same
// stimulus and are compared each cycle against a slot/queue model, plus hand-computed checks.
module tb_fp32_add_arbiter;

    localparam int N  = 4;
    localparam int CW = 32;
    localparam int LAT [2] = '{1, 3};

    // Operand pairs and their hand-computed IEEE-754 single-precision sums.
    localparam logic [31:0] PA [6] = '{32'h3F800000, 32'h7F800000, 32'h40800000,
                                      32'h41200000, 32'hBF800000, 32'h3F000000};
    localparam logic [31:0] PB [6] = '{32'h40000000, 32'hFF800000, 32'h40800000,
                                      32'hC0400000, 32'h3F800000, 32'h3F000000};
    localparam logic [31:0] PS [6] = '{32'h40400000, 32'h7FC00000, 32'h41000000,
                                      32'h40E00000, 32'h00000000, 32'h3F800000};

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [32*N-1:0]   req_a;
    logic [32*N-1:0]   req_b;
    logic [N-1:0]      rsp_ready;
    logic [N-1:0]      req_ready [2];
    logic [N-1:0]      rsp_valid [2];
    logic [32*N-1:0]   rsp_data  [2];
    logic [31:0]       add_a     [2];
    logic [31:0]       add_b     [2];
    logic              busy      [2];
    logic [CW-1:0]     issue_cnt [2];
    logic [31:0]       sum1_q;
    logic [31:0]       sum3_q    [3];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Model state per build
    logic [N-1:0]  m_occ [2];
    logic [N-1:0]  m_rv  [2];
    logic [31:0]   m_rd  [2][N];
    int            m_ptr [2];
    logic [CW-1:0] m_cnt [2];
    logic [31:0]   m_a   [2];
    logic [31:0]   m_b   [2];
    int            due   [2][N];
    logic [31:0]   pdata [2][N];

    fp32_add_arbiter #(.N_REQ(N), .ADD_LAT(1), .CNT_W(CW)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
        .rsp_ready(rsp_ready), .add_a(add_a[0]), .add_b(add_b[0]), .add_sum(sum1_q),
        .busy(busy[0]), .issue_cnt(issue_cnt[0])
    );

    fp32_add_arbiter #(.N_REQ(N), .ADD_LAT(3), .CNT_W(CW)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
        .rsp_ready(rsp_ready), .add_a(add_a[1]), .add_b(add_b[1]), .add_sum(sum3_q[2]),
        .busy(busy[1]), .issue_cnt(issue_cnt[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stand-in fp32 adder covering the operand pairs used here.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h3F800000_40000000: return 32'h40400000;
            64'h7F800000_FF800000: return 32'h7FC00000;
            64'h40800000_40800000: return 32'h41000000;
            64'h41200000_C0400000: return 32'h40E00000;
            64'hBF800000_3F800000: return 32'h00000000;
            64'h3F000000_3F000000: return 32'h3F800000;
            default:               return a ^ {b[15:0], b[31:16]};
        endcase
    endfunction

    always @(posedge clk) begin
        sum1_q    <= fadd(add_a[0], add_b[0]);
        sum3_q[0] <= fadd(add_a[1], add_b[1]);
        sum3_q[1] <= sum3_q[0];
        sum3_q[2] <= sum3_q[1];
    end

    task automatic chk(input string name, input int u, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s (lat=%0d, cyc=%0d): got %0h, expected %0h",
                     name, LAT[u], cyc, got, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] occ, input int ptr);
        int c;
        for (int k = 0; k < N; k++) begin
            c = (ptr + k) % N;
            if (req_valid[c[1:0]] && !occ[c[1:0]]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_occ[u] = '0; m_rv[u] = '0; m_ptr[u] = 0; m_cnt[u] = '0;
            m_a[u] = '0;   m_b[u] = '0;
            for (int i = 0; i < N; i++) begin
                m_rd[u][i] = '0; due[u][i] = -1; pdata[u][i] = '0;
            end
        end
    endtask

    // One clock edge: consume handshakes, land results that are due, accept one grant.
    task automatic model_step(input int u);
        int g;
        g = pick(m_occ[u], m_ptr[u]);
        for (int i = 0; i < N; i++) begin
            if (m_rv[u][i] && rsp_ready[i]) begin
                m_rv[u][i] = 1'b0; m_occ[u][i] = 1'b0;
            end
            if (due[u][i] == cyc) begin
                m_rv[u][i] = 1'b1; m_rd[u][i] = pdata[u][i]; due[u][i] = -1;
            end
        end
        if (g >= 0) begin
            m_occ[u][g[1:0]] = 1'b1;
            due[u][g]        = cyc + LAT[u] + 1;
            pdata[u][g]      = fadd(req_a[32*g +: 32], req_b[32*g +: 32]);
            m_a[u]           = req_a[32*g +: 32];
            m_b[u]           = req_b[32*g +: 32];
            m_ptr[u]         = (g + 1) % N;
            m_cnt[u]         = m_cnt[u] + 1;
        end
    endtask

    task automatic compare(input int u);
        logic [N-1:0]   er;
        logic [127:0]   ed;
        int             g;
        g  = pick(m_occ[u], m_ptr[u]);
        er = '0;
        if (g >= 0) er[g[1:0]] = 1'b1;
        for (int i = 0; i < N; i++) ed[32*i +: 32] = m_rd[u][i];
        chk("req_ready", u, req_ready[u], er);
        chk("rsp_valid", u, rsp_valid[u], m_rv[u]);
        chk("rsp_data",  u, rsp_data[u],  ed);
        chk("add_a",     u, add_a[u],     m_a[u]);
        chk("add_b",     u, add_b[u],     m_b[u]);
        chk("busy",      u, busy[u],      |m_occ[u]);
        chk("issue_cnt", u, issue_cnt[u], m_cnt[u]);
    endtask

    // Model update on each rising edge, comparison on each falling edge.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) model_reset();
            else for (int u = 0; u < 2; u++) model_step(u);
            cyc++;
            @(negedge clk);
            if (rst) model_reset();
            for (int u = 0; u < 2; u++) compare(u);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int p);
        req_a[32*i +: 32] = PA[p];
        req_b[32*i +: 32] = PB[p];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; rsp_ready = '1; req_a = '0; req_b = '0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        for (int u = 0; u < 2; u++) begin
            chk("rst_rsp_valid", u, rsp_valid[u], 0);
            chk("rst_busy", u, busy[u], 0);
            chk("rst_issue_cnt", u, issue_cnt[u], 0);
            chk("rst_add_a", u, add_a[u], 0);
        end

        // Single requester 0: 1.0 + 2.0
        set_req(0, 0); req_valid = 4'b0001;
        #1; chk("t1_ready", 0, req_ready[0], 4'b0001);
        tick();                                     // E0
        req_valid = '0;
        for (int u = 0; u < 2; u++) begin
            chk("t1_add_a", u, add_a[u], 32'h3F800000);
            chk("t1_issue_cnt", u, issue_cnt[u], 1);
        end
        tick();                                     // E1
        chk("t1_rsp_e1", 0, rsp_valid[0], 4'b0000);
        tick();                                     // E2
        chk("t1_rsp_e2", 0, rsp_valid[0], 4'b0001);
        chk("t1_data", 0, rsp_data[0][31:0], 32'h40400000);
        chk("t1_lat3_e2", 1, rsp_valid[1], 4'b0000);
        tick();                                     // E3
        chk("t1_rsp_e3", 0, rsp_valid[0], 4'b0000);
        chk("t1_busy_e3", 0, busy[0], 0);
        tick();                                     // E4
        chk("t1_lat3_e4", 1, rsp_valid[1], 4'b0001);
        chk("t1_lat3_data", 1, rsp_data[1][31:0], 32'h40400000);
        repeat (3) tick();

        // All four valid: grants 0,1,2,3 then wrap to 0
        do_reset();
        set_req(0, 0); set_req(1, 2); set_req(2, 3); set_req(3, 5);
        req_valid = 4'b1111;
        for (int g = 0; g < 4; g++) begin
            tick();
            for (int u = 0; u < 2; u++) begin
                chk("t2_order_a", u, add_a[u], (g == 0) ? PA[0] : (g == 1) ? PA[2] :
                                               (g == 2) ? PA[3] : PA[5]);
                chk("t2_cnt", u, issue_cnt[u], g + 1);
            end
        end
        tick();
        chk("t2_wrap_a", 0, add_a[0], PA[0]);
        chk("t2_wrap_cnt", 0, issue_cnt[0], 5);
        req_valid = '0;
        repeat (8) tick();
        for (int u = 0; u < 2; u++) begin
            chk("t2_route", u, rsp_data[u], {PS[5], PS[3], PS[2], PS[0]});
            chk("t2_idle", u, busy[u], 0);
        end

        // Backpressure on requester 2
        rsp_ready = 4'b1011;
        set_req(2, 4);
        req_valid = 4'b1111;
        repeat (4) tick();
        repeat (10) begin
            tick();
            for (int u = 0; u < 2; u++) chk("t3_ready2_low", u, req_ready[u][2], 0);
            chk("t3_hold", 0, rsp_data[0][95:64], PS[4]);
        end
        req_valid = 4'b0100;
        repeat (6) tick();
        for (int u = 0; u < 2; u++) begin
            chk("t3_held_valid", u, rsp_valid[u], 4'b0100);
            chk("t3_held_data", u, rsp_data[u][95:64], PS[4]);
        end
        rsp_ready = 4'b1111;
        #1; chk("t3_no_regrant", 0, req_ready[0], 4'b0000);
        tick();                                     // handshake edge
        for (int u = 0; u < 2; u++) begin
            chk("t3_consumed", u, rsp_valid[u], 4'b0000);
            chk("t3_ready_after", u, req_ready[u], 4'b0100);
        end
        tick();                                     // re-accept edge
        for (int u = 0; u < 2; u++) chk("t3_reaccept", u, add_a[u], PA[4]);
        req_valid = '0;
        repeat (6) tick();
        for (int u = 0; u < 2; u++) chk("t3_drained", u, busy[u], 0);

        // Inf + -Inf -> NaN, routed to requester 1 only
        set_req(1, 1); req_valid = 4'b0010;
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("t4_valid", 0, rsp_valid[0], 4'b0010);
        chk("t4_nan", 0, rsp_data[0][63:32], 32'h7FC00000);
        repeat (4) tick();
        chk("t4_nan_lat3", 1, rsp_data[1][63:32], 32'h7FC00000);

        // Reset one cycle after accepting requester 3
        set_req(3, 2); req_valid = 4'b1000;
        tick();
        req_valid = '0;
        chk("t5_busy", 0, busy[0], 1);
        tick();
        rst = 1'b1;
        #1;
        for (int u = 0; u < 2; u++) begin
            chk("t5_rst_valid", u, rsp_valid[u], 0);
            chk("t5_rst_data", u, rsp_data[u], 0);
            chk("t5_rst_add", u, {add_a[u], add_b[u]}, 0);
            chk("t5_rst_busy", u, busy[u], 0);
            chk("t5_rst_cnt", u, issue_cnt[u], 0);
        end
        tick();
        rst = 1'b0;
        repeat (6) begin
            tick();
            for (int u = 0; u < 2; u++) begin
                chk("t5_no_late_rsp", u, rsp_valid[u], 0);
                chk("t5_idle", u, busy[u], 0);
            end
        end

        // Back-to-back accepts from 0 and 1; latency-3 return order
        set_req(0, 3); set_req(1, 5); req_valid = 4'b0011;
        tick();                                     // E0
        tick();                                     // E1
        req_valid = '0;
        chk("t6_cnt", 1, issue_cnt[1], 2);
        tick();
        tick();                                     // E3
        chk("t6_e3", 1, rsp_valid[1], 4'b0000);
        tick();                                     // E4
        chk("t6_e4", 1, rsp_valid[1], 4'b0001);
        chk("t6_data0", 1, rsp_data[1][31:0], PS[3]);
        tick();                                     // E5
        chk("t6_e5", 1, rsp_valid[1], 4'b0010);
        chk("t6_data1", 1, rsp_data[1][63:32], PS[5]);
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
